core_io_bank: RTL and testbench

CORE_IO_BANK -- requirements
Module: core_io_bank

---
 rtl/core_io_pkg.sv | 20 ++
 rtl/core_io_bank_if.sv | 15 +
 rtl/io_addr_decode.sv | 28 ++
 rtl/core_io_bank.sv | 120 ++++++++++++
 tb/tb_core_io_bank.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_io_pkg.sv
// Shared definitions for the core I/O bank: default base address, STATUS
// register placement and bit positions, and the decoded-address struct.
package core_io_pkg;

    localparam logic [31:0] IO_BASE_ADDR     = 32'h0001_0000;
    localparam int          STATUS_VALID_LSB = 0;
    localparam int          STATUS_OVR_LSB   = 16;

    typedef struct packed {
        logic       hit;
        logic       is_status;
        logic [3:0] ch;
    } io_dec_t;

    // STATUS sits directly after the last channel data word.
    function automatic logic [31:0] status_offset(input int num_ch);
        return 32'(4 * num_ch);
    endfunction

endpackage

// File: rtl/core_io_bank_if.sv
// Core-side load/store bus of the I/O bank. The master drives the request,
// the slave returns the window hit and the registered load data.
interface core_io_bank_if;

    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        re;
    logic        hit;
    logic [31:0] rdata;

    modport master (output addr, we, wdata, re, input hit, rdata);
    modport slave  (input addr, we, wdata, re, output hit, rdata);

endinterface

// File: rtl/io_addr_decode.sv
// Combinational decode of the bus address into hit / STATUS / channel index.
// Only exact word addresses inside the window hit.
module io_addr_decode
    import core_io_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter logic [31:0] BASE_ADDR = IO_BASE_ADDR
) (
    core_io_bank_if.slave bus,
    output io_dec_t       dec_o
);

    logic [31:0] off;

    always_comb begin
        off   = bus.addr - BASE_ADDR;
        dec_o = '0;
        // Addresses below the base wrap to large offsets and miss.
        if (off == status_offset(NUM_CH)) begin
            dec_o.hit       = 1'b1;
            dec_o.is_status = 1'b1;
        end else if (off[1:0] == 2'b00 && off < status_offset(NUM_CH)) begin
            dec_o.hit = 1'b1;
            dec_o.ch  = off[5:2];
        end
    end

endmodule

// File: rtl/core_io_bank.sv
// Memory-mapped bank of NUM_CH output channels with valid/ready hand-off,
// sticky overrun flags and a STATUS word. The load path is built only when
// CORE_IO_BANK_READBACK_EN is defined; otherwise rdata_o is tied to 0.
module core_io_bank
    import core_io_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = IO_BASE_ADDR
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [31:0]             addr_i,
    input  logic [3:0]              we_i,
    input  logic [31:0]             wdata_i,
    input  logic                    re_i,
    output logic                    hit_o,
    output logic [31:0]             rdata_o,
    output logic [NUM_CH*WIDTH-1:0] ch_data_o,
    output logic [NUM_CH-1:0]       ch_valid_o,
    input  logic [NUM_CH-1:0]       ch_ready_i,
    output logic [NUM_CH-1:0]       overrun_o
);

    localparam int LANES = WIDTH / 8;

    core_io_bank_if bus ();
    io_dec_t        dec;

    assign bus.addr  = addr_i;
    assign bus.we    = we_i;
    assign bus.wdata = wdata_i;
    assign bus.re    = re_i;

    io_addr_decode #(
        .NUM_CH    (NUM_CH),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .bus   (bus.slave),
        .dec_o (dec)
    );

    assign bus.hit = dec.hit;
    assign hit_o   = bus.hit;

    logic [WIDTH-1:0]  data_q [NUM_CH];
    logic [WIDTH-1:0]  data_d [NUM_CH];
    logic [NUM_CH-1:0] valid_q, valid_d;
    logic [NUM_CH-1:0] ovr_q, ovr_d;
    logic [NUM_CH-1:0] wr_ch, ovr_clr;

    // A channel write while valid always reloads and keeps valid set; it is
    // an overrun only when the consumer did not take the old word this cycle.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            wr_ch[k]   = (|bus.we) && dec.hit && !dec.is_status && (dec.ch == 4'(k));
            ovr_clr[k] = dec.hit && dec.is_status
                         && bus.we[(STATUS_OVR_LSB + k) / 8]
                         && bus.wdata[STATUS_OVR_LSB + k];
            data_d[k]  = data_q[k];
            if (wr_ch[k]) begin
                for (int b = 0; b < LANES; b++) begin
                    if (bus.we[b]) data_d[k][b*8 +: 8] = bus.wdata[b*8 +: 8];
                end
            end
            valid_d[k] = wr_ch[k] | (valid_q[k] & ~ch_ready_i[k]);
            ovr_d[k]   = (wr_ch[k] & valid_q[k] & ~ch_ready_i[k]) | (ovr_q[k] & ~ovr_clr[k]);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < NUM_CH; k++) data_q[k] <= '0;
            valid_q <= '0;
            ovr_q   <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) data_q[k] <= data_d[k];
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ch_data_o[k*WIDTH +: WIDTH] = data_q[k];
    end
    assign ch_valid_o = valid_q;
    assign overrun_o  = ovr_q;

`ifdef CORE_IO_BANK_READBACK_EN
    logic [31:0] status, rd_word, rdata_q, rdata_d;

    // Read mux samples pre-write state, so a same-cycle store+load returns old data.
    always_comb begin
        status = (32'(valid_q) << STATUS_VALID_LSB) | (32'(ovr_q) << STATUS_OVR_LSB);
        rd_word = '0;
        if (dec.is_status) begin
            rd_word = status;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (dec.ch == 4'(k)) rd_word = 32'(data_q[k]);
            end
        end
        rdata_d = (bus.re && dec.hit) ? rd_word : '0;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) rdata_q <= '0;
        else         rdata_q <= rdata_d;
    end

    assign bus.rdata = rdata_q;
`else
    logic unused_re;
    assign unused_re = bus.re;
    assign bus.rdata = '0;
`endif

    assign rdata_o = bus.rdata;

endmodule

// File: tb/tb_core_io_bank.sv
// Bench for core_io_bank: a 32-bit and a 16-bit instance share one request
// bus and are checked every cycle against a channel-level reference model.
module tb_core_io_bank;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk;
  logic        rstn;
  logic [3:0]  ready;
  logic        hit16;
  logic [31:0] rdata16;
  logic [127:0] ch_data32;
  logic [63:0]  ch_data16;
  logic [3:0]  valid32, valid16, ovr32, ovr16;

  core_io_bank_if bus ();

  core_io_bank #(.NUM_CH(4), .WIDTH(32), .BASE_ADDR(BASE)) u_dut32 (
    .clk_i(clk), .rstn_i(rstn), .addr_i(bus.addr), .we_i(bus.we),
    .wdata_i(bus.wdata), .re_i(bus.re), .hit_o(bus.hit), .rdata_o(bus.rdata),
    .ch_data_o(ch_data32), .ch_valid_o(valid32), .ch_ready_i(ready), .overrun_o(ovr32)
  );

  core_io_bank #(.NUM_CH(4), .WIDTH(16), .BASE_ADDR(BASE)) u_dut16 (
    .clk_i(clk), .rstn_i(rstn), .addr_i(bus.addr), .we_i(bus.we),
    .wdata_i(bus.wdata), .re_i(bus.re), .hit_o(hit16), .rdata_o(rdata16),
    .ch_data_o(ch_data16), .ch_valid_o(valid16), .ch_ready_i(ready), .overrun_o(ovr16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: index 0 = 32-bit instance, 1 = 16-bit instance
  int          n_tests = 0;
  int          n_fail  = 0;
  int          wid [2];
  logic [31:0] m_data [2][4];
  logic [3:0]  m_valid [2];
  logic [3:0]  m_ovr [2];
  logic [31:0] m_rdata [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) m_data[i][k] = '0;
      m_valid[i] = '0;
      m_ovr[i]   = '0;
      m_rdata[i] = '0;
    end
  endtask

  function automatic logic [31:0] status_word(input int i);
    return {12'h000, m_ovr[i], 12'h000, m_valid[i]};
  endfunction

  task automatic check_all(input string tag);
    check({tag, ":valid32"}, 32'(valid32), 32'(m_valid[0]));
    check({tag, ":valid16"}, 32'(valid16), 32'(m_valid[1]));
    check({tag, ":ovr32"},   32'(ovr32),   32'(m_ovr[0]));
    check({tag, ":ovr16"},   32'(ovr16),   32'(m_ovr[1]));
    check({tag, ":rdata32"}, bus.rdata,    m_rdata[0]);
    check({tag, ":rdata16"}, rdata16,      m_rdata[1]);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s:data32[%0d]", tag, k), ch_data32[k*32 +: 32], m_data[0][k]);
      check($sformatf("%s:data16[%0d]", tag, k), 32'(ch_data16[k*16 +: 16]), m_data[1][k]);
    end
  endtask

  // driver: entered on a falling edge, applies one bus cycle, checks the
  // combinational hit, advances the model across the rising edge and checks
  task automatic step(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                      input logic re, input logic [3:0] rdy, input string tag);
    logic        hit, st;
    int          ch;
    logic [31:0] lane_mask;
    logic [31:0] n_data [2][4];
    logic [3:0]  n_valid [2];
    logic [3:0]  n_ovr [2];
    logic [31:0] n_rd [2];
    bus.addr = a; bus.we = we; bus.wdata = wd; bus.re = re; ready = rdy;
    #1;
    hit = 1'b0; st = 1'b0; ch = 0;
    for (int k = 0; k < 4; k++) if (a == BASE + 32'(4 * k)) begin hit = 1'b1; ch = k; end
    if (a == BASE + 32'd16) begin hit = 1'b1; st = 1'b1; end
    check({tag, ":hit32"}, 32'(bus.hit), 32'(hit));
    check({tag, ":hit16"}, 32'(hit16),   32'(hit));
    for (int i = 0; i < 2; i++) begin
      lane_mask = '0;
      for (int b = 0; b < 4; b++) if (we[b] && b * 8 < wid[i]) lane_mask |= 32'hFF << (8 * b);
      n_rd[i] = '0;
`ifdef CORE_IO_BANK_READBACK_EN
      if (re && hit) n_rd[i] = st ? status_word(i) : m_data[i][ch];
`endif
      for (int k = 0; k < 4; k++) begin
        n_data[i][k]  = m_data[i][k];
        n_valid[i][k] = m_valid[i][k] & ~rdy[k];
        n_ovr[i][k]   = m_ovr[i][k];
        if (hit && !st && ch == k && we != 4'h0) begin
          n_data[i][k]  = (m_data[i][k] & ~lane_mask) | (wd & lane_mask);
          n_valid[i][k] = 1'b1;
          if (m_valid[i][k] && !rdy[k]) n_ovr[i][k] = 1'b1;
        end
        if (hit && st && we[(16 + k) / 8] && wd[16 + k]) n_ovr[i][k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) m_data[i][k] = n_data[i][k];
      m_valid[i] = n_valid[i];
      m_ovr[i]   = n_ovr[i];
      m_rdata[i] = n_rd[i];
    end
    check_all(tag);
    @(negedge clk);
  endtask

  // scoreboard queue of spot values written by directed steps
  logic [31:0] exp_q [$];
  logic [31:0] exp_rd;
  logic [31:0] ra;

  initial begin
    wid[0] = 32; wid[1] = 16;
    model_reset();
    rstn = 1'b0; ready = '0;
    bus.addr = '0; bus.we = '0; bus.wdata = '0; bus.re = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset");
    rstn = 1'b1;

    // first write lands on the first edge after reset release
    step(BASE + 32'h4, 4'hF, 32'hDEADBEEF, 1'b0, 4'b0000, "w_ch1");
    check("w_ch1:const_data", ch_data32[63:32], 32'hDEADBEEF);
    check("w_ch1:const_valid", 32'(valid32), 32'h2);
    step(32'h0, 4'h0, 32'h0, 1'b0, 4'b0010, "accept_ch1");
    check("accept_ch1:const_valid", 32'(valid32), 32'h0);

    // byte lanes, narrow channel
    step(BASE, 4'hF, 32'h12345678, 1'b0, 4'b0000, "lanes_full");
    check("lanes_full:w16", 32'(ch_data16[15:0]), 32'h5678);
    step(BASE, 4'h2, 32'h0000AB00, 1'b0, 4'b0000, "lanes_b1");
    check("lanes_b1:w16", 32'(ch_data16[15:0]), 32'hAB78);
    check("lanes_b1:w32", ch_data32[31:0], 32'h1234AB78);
    step(32'h0, 4'h0, 32'h0, 1'b0, 4'b0001, "accept_ch0");
    step(BASE + 32'h10, 4'h4, 32'h0001_0000, 1'b0, 4'b0000, "clr_ovr0");

    // overrun on channel 2, STATUS read and clear
    step(BASE + 32'h8, 4'hF, 32'h1111_1111, 1'b0, 4'b0000, "ovr_w1");
    step(BASE + 32'h8, 4'hF, 32'h2222_2222, 1'b0, 4'b0000, "ovr_w2");
    check("ovr_w2:const_ovr", 32'(ovr32), 32'h4);
    step(BASE + 32'h10, 4'h0, 32'h0, 1'b1, 4'b0000, "status_rd");
`ifdef CORE_IO_BANK_READBACK_EN
    exp_q.push_back(32'h0004_0004);
`else
    exp_q.push_back(32'h0000_0000);
`endif
    check("status_rd:const", bus.rdata, exp_q.pop_front());
    step(BASE + 32'h10, 4'hF, 32'h0004_0000, 1'b0, 4'b0000, "status_clr");
    check("status_clr:const_ovr", 32'(ovr32), 32'h0);
    check("status_clr:const_valid", 32'(valid32), 32'h4);

    // reload while consumer accepts: no overrun
    step(BASE + 32'hC, 4'hF, 32'h0000_00A1, 1'b0, 4'b0000, "ch3_w1");
    step(BASE + 32'hC, 4'hF, 32'h0000_00B2, 1'b0, 4'b1000, "ch3_w2");
    check("ch3_w2:const_data", ch_data32[127:96], 32'h0000_00B2);
    check("ch3_w2:const_ovr", 32'(ovr32[3]), 32'h0);

    // loads: hit, miss, same-cycle store+load
    step(32'h0, 4'h0, 32'h0, 1'b0, 4'b1111, "drain");
    step(BASE, 4'hF, 32'hCAFE0001, 1'b0, 4'b0000, "ld_store");
    step(BASE, 4'h0, 32'h0, 1'b1, 4'b0000, "ld_hit");
`ifdef CORE_IO_BANK_READBACK_EN
    exp_rd = 32'hCAFE0001;
`else
    exp_rd = 32'h0;
`endif
    check("ld_hit:const", bus.rdata, exp_rd);
    step(32'h0002_0000, 4'h0, 32'h0, 1'b1, 4'b0000, "ld_miss");
    check("ld_miss:const", bus.rdata, 32'h0);
    step(BASE, 4'hF, 32'h5555_5555, 1'b1, 4'b0000, "ld_rmw");
    check("ld_rmw:const", bus.rdata, exp_rd);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: ra = BASE + 32'(4 * $urandom_range(0, 3));
        4:          ra = BASE + 32'h10;
        5:          ra = 32'h0002_0000;
        6:          ra = BASE - 32'h4;
        7:          ra = BASE + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(1, 3));
        8:          ra = BASE + 32'h14;
        default:    ra = $urandom;
      endcase
      step(ra, ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $sformatf("rnd%0d", n));
    end

    // asynchronous reset in the middle of a pending hand-off
    step(BASE + 32'h4, 4'hF, 32'hA5A5_5A5A, 1'b1, 4'b0000, "pre_rst");
    ready = 4'b0010;
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst:const_valid", 32'(valid32), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    step(BASE, 4'hF, 32'h0BAD_F00D, 1'b0, 4'b0000, "post_rst_w");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
